// File: rtl/instr_byte_queue.sv
// Circular byte queue between the instruction fetcher and the decoder.
// Fetch blocks are appended at wr_ptr, and the decoder peeks and consumes bytes at rd_ptr.
module instr_byte_queue #(
    parameter int DEPTH_BYTES = 128,
    parameter int HIGHWATER   = 115,
    parameter int LOWWATER    = 51,
    parameter int FILL_BYTES  = 8,
    parameter int WIN_BYTES   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    fill_valid,
    output logic                    fill_ready,
    input  logic [8*FILL_BYTES-1:0] fill_data,
    input  logic [3:0]              fill_count,
    input  logic                    take_en,
    input  logic [4:0]              take_count,
    input  logic                    flush,
    input  logic [63:0]             flush_ip,
    output logic [8*WIN_BYTES-1:0]  win_data,
    output logic [4:0]              win_bytes,
    output logic [63:0]             head_ip,
    output logic [7:0]              count,
    output logic                    can_fetch,
    output logic                    take_err
);

    localparam int PW = $clog2(DEPTH_BYTES);

    logic [7:0]    mem [DEPTH_BYTES];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    logic [3:0] fill_n;
    logic       fill_acc;
    logic [4:0] take_req;
    logic [4:0] eff;
    logic       over;
    logic [7:0] count_next;

    // Fill handshake: a beat transfers on a cycle where fill_valid and fill_ready are both high.
    // fill_ready depends only on registered occupancy, so it never waits on a same-cycle take.
    assign fill_ready = (32'(count) + FILL_BYTES) <= DEPTH_BYTES;
    assign win_bytes  = (32'(count) >= WIN_BYTES) ? 5'(WIN_BYTES) : count[4:0];

    always_comb begin
        fill_n     = (32'(fill_count) > FILL_BYTES) ? 4'(FILL_BYTES) : fill_count;
        fill_acc   = fill_valid & fill_ready;
        take_req   = take_en ? take_count : 5'd0;
        over       = take_req > win_bytes;
        eff        = over ? win_bytes : take_req;
        count_next = count + (fill_acc ? 8'(fill_n) : 8'd0) - 8'(eff);
    end

    // The peek window wraps naturally because the pointer arithmetic is modulo depth.
    always_comb begin
        win_data = '0;
        for (int i = 0; i < WIN_BYTES; i++) begin
            win_data[8*i +: 8] = mem[rd_ptr + PW'(i)];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush && fill_acc) begin
            for (int k = 0; k < FILL_BYTES; k++) begin
                if (k < int'(fill_n)) begin
                    mem[wr_ptr + PW'(k)] <= fill_data[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            head_ip   <= '0;
            can_fetch <= 1'b1;
            take_err  <= 1'b0;
        end else if (flush) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            head_ip   <= flush_ip;
            can_fetch <= 1'b1;
            take_err  <= 1'b0;
        end else begin
            if (fill_acc) begin
                wr_ptr <= wr_ptr + PW'(fill_n);
            end
            rd_ptr   <= rd_ptr + PW'(eff);
            head_ip  <= head_ip + 64'(eff);
            count    <= count_next;
            take_err <= over;
            // Hysteresis: between the water marks the hint keeps its previous value.
            if (32'(count_next) >= HIGHWATER) begin
                can_fetch <= 1'b0;
            end else if (32'(count_next) <= LOWWATER) begin
                can_fetch <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_byte_queue.sv
// Self-checking bench for instr_byte_queue: vector table plus hand-written
// sequences for fill-to-full hysteresis, wrap-around and mid-stream reset.
module tb_instr_byte_queue;

    logic         clk = 1'b0;
    logic         rst;
    logic         fill_valid;
    logic         fill_ready;
    logic [63:0]  fill_data;
    logic [3:0]   fill_count;
    logic         take_en;
    logic [4:0]   take_count;
    logic         flush;
    logic [63:0]  flush_ip;
    logic [127:0] win_data;
    logic [4:0]   win_bytes;
    logic [63:0]  head_ip;
    logic [7:0]   count;
    logic         can_fetch;
    logic         take_err;

    instr_byte_queue dut (
        .clk(clk), .rst(rst),
        .fill_valid(fill_valid), .fill_ready(fill_ready),
        .fill_data(fill_data), .fill_count(fill_count),
        .take_en(take_en), .take_count(take_count),
        .flush(flush), .flush_ip(flush_ip),
        .win_data(win_data), .win_bytes(win_bytes), .head_ip(head_ip),
        .count(count), .can_fetch(can_fetch), .take_err(take_err)
    );

    always #5 clk = ~clk;

    // Scoreboard: bytes pushed when a fill is accepted, popped when the decoder takes them.
    logic [7:0] exp_q[$];
    logic [7:0] byte_seq;
    int checks = 0;
    int passed = 0;

    typedef struct {
        logic        fv;
        logic [3:0]  fc;
        logic        te;
        logic [4:0]  tc;
        logic        fl;
        logic [63:0] fip;
        int          e_count;
        int          e_wb;
        logic [63:0] e_hip;
        logic        e_cf;
        logic        e_err;
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [63:0] seq_beat();
        logic [63:0] b;
        for (int k = 0; k < 8; k++) b[8*k +: 8] = byte_seq + 8'(k);
        return b;
    endfunction

    task automatic idle_inputs();
        rst = 1'b0; fill_valid = 1'b0; fill_data = '0; fill_count = '0;
        take_en = 1'b0; take_count = '0; flush = 1'b0; flush_ip = '0;
    endtask

    // One clock cycle with the given inputs; the scoreboard is updated from the bench's own view of occupancy.
    task automatic cyc(input logic fv, input logic [3:0] fc, input logic [63:0] fd,
                       input logic te, input logic [4:0] tc,
                       input logic fl, input logic [63:0] fip, input logic r);
        int sz, wb, eff;
        logic acc;
        rst = r; fill_valid = fv; fill_count = fc; fill_data = fd;
        take_en = te; take_count = tc; flush = fl; flush_ip = fip;
        sz  = exp_q.size();
        wb  = (sz < 16) ? sz : 16;
        eff = te ? ((int'(tc) > wb) ? wb : int'(tc)) : 0;
        acc = fv && (sz + 8 <= 128);
        @(posedge clk);
        #1;
        if (r || fl) begin
            exp_q.delete();
            byte_seq = 8'h00;
        end else begin
            for (int i = 0; i < eff; i++) void'(exp_q.pop_front());
            if (acc) begin
                for (int k = 0; k < int'(fc); k++) exp_q.push_back(fd[8*k +: 8]);
                byte_seq = byte_seq + 8'(fc);
            end
        end
        idle_inputs();
    endtask

    task automatic fill_seq(input logic [3:0] fc, input logic te, input logic [4:0] tc);
        cyc(1'b1, fc, seq_beat(), te, tc, 1'b0, 64'h0, 1'b0);
    endtask

    task automatic check_state(input string tag, input int e_count, input int e_wb,
                               input logic [63:0] e_hip, input logic e_cf, input logic e_err);
        chk({tag, ".count"}, 64'(count), 64'(e_count));
        chk({tag, ".win_bytes"}, 64'(win_bytes), 64'(e_wb));
        chk({tag, ".head_ip"}, head_ip, e_hip);
        chk({tag, ".can_fetch"}, 64'(can_fetch), 64'(e_cf));
        chk({tag, ".take_err"}, 64'(take_err), 64'(e_err));
        chk({tag, ".fill_ready"}, 64'(fill_ready), 64'(e_count <= 120));
        for (int i = 0; i < e_wb && i < exp_q.size(); i++)
            chk($sformatf("%s.win_byte%0d", tag, i), 64'(win_data[8*i +: 8]), 64'(exp_q[i]));
    endtask

    initial begin
        idle_inputs();
        byte_seq = 8'h00;

        vecs[0]  = '{1'b1, 4'd8, 1'b0, 5'd0,  1'b0, 64'h0,    8,  8,  64'h0,    1'b1, 1'b0};
        vecs[1]  = '{1'b1, 4'd8, 1'b0, 5'd0,  1'b0, 64'h0,    16, 16, 64'h0,    1'b1, 1'b0};
        vecs[2]  = '{1'b1, 4'd8, 1'b0, 5'd0,  1'b0, 64'h0,    24, 16, 64'h0,    1'b1, 1'b0};
        vecs[3]  = '{1'b0, 4'd0, 1'b0, 5'd0,  1'b1, 64'h1000, 0,  0,  64'h1000, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 4'd8, 1'b0, 5'd0,  1'b0, 64'h0,    8,  8,  64'h1000, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 4'd8, 1'b0, 5'd0,  1'b0, 64'h0,    16, 16, 64'h1000, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 4'd8, 1'b0, 5'd0,  1'b0, 64'h0,    24, 16, 64'h1000, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 4'd0, 1'b1, 5'd5,  1'b0, 64'h0,    19, 16, 64'h1005, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 4'd3, 1'b1, 5'd16, 1'b0, 64'h0,    6,  6,  64'h1015, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 4'd0, 1'b1, 5'd7,  1'b0, 64'h0,    0,  0,  64'h101B, 1'b1, 1'b1};
        vecs[10] = '{1'b0, 4'd0, 1'b0, 5'd0,  1'b0, 64'h0,    0,  0,  64'h101B, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 4'd0, 1'b1, 5'd3,  1'b0, 64'h0,    0,  0,  64'h101B, 1'b1, 1'b1};
        vecs[12] = '{1'b0, 4'd0, 1'b0, 5'd9,  1'b0, 64'h0,    0,  0,  64'h101B, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 4'd0, 1'b0, 5'd0,  1'b0, 64'h0,    0,  0,  64'h101B, 1'b1, 1'b0};
        vecs[14] = '{1'b1, 4'd3, 1'b0, 5'd0,  1'b0, 64'h0,    3,  3,  64'h101B, 1'b1, 1'b0};
        vecs[15] = '{1'b0, 4'd0, 1'b1, 5'd7,  1'b0, 64'h0,    0,  0,  64'h101E, 1'b1, 1'b1};
        vecs[16] = '{1'b1, 4'd8, 1'b0, 5'd0,  1'b0, 64'h0,    8,  8,  64'h101E, 1'b1, 1'b0};
        vecs[17] = '{1'b1, 4'd8, 1'b1, 5'd4,  1'b1, 64'h2000, 0,  0,  64'h2000, 1'b1, 1'b0};
        vecs[18] = '{1'b0, 4'd0, 1'b1, 5'd0,  1'b0, 64'h0,    0,  0,  64'h2000, 1'b1, 1'b0};
        vecs[19] = '{1'b1, 4'd8, 1'b0, 5'd0,  1'b0, 64'h0,    8,  8,  64'h2000, 1'b1, 1'b0};

        // Reset state
        cyc(1'b0, 4'd0, 64'h0, 1'b0, 5'd0, 1'b0, 64'h0, 1'b1);
        cyc(1'b0, 4'd0, 64'h0, 1'b0, 5'd0, 1'b0, 64'h0, 1'b1);
        check_state("reset", 0, 0, 64'h0, 1'b1, 1'b0);

        for (int v = 0; v < 20; v++) begin
            cyc(vecs[v].fv, vecs[v].fc, seq_beat(), vecs[v].te, vecs[v].tc,
                vecs[v].fl, vecs[v].fip, 1'b0);
            check_state($sformatf("vec%0d", v), vecs[v].e_count, vecs[v].e_wb,
                        vecs[v].e_hip, vecs[v].e_cf, vecs[v].e_err);
            if (v == 7) chk("vec7.byte0_is_05", 64'(win_data[7:0]), 64'h05);
        end

        // Fill to full: can_fetch clears once occupancy reaches 120, fill_ready clears at 128
        cyc(1'b0, 4'd0, 64'h0, 1'b0, 5'd0, 1'b0, 64'h0, 1'b1);
        for (int i = 1; i <= 16; i++) begin
            fill_seq(4'd8, 1'b0, 5'd0);
            check_state($sformatf("full%0d", i), 8*i, (8*i < 16) ? 8*i : 16, 64'h0, i < 15, 1'b0);
        end
        fill_seq(4'd8, 1'b0, 5'd0);
        check_state("full_ignored", 128, 16, 64'h0, 1'b0, 1'b0);
        for (int j = 1; j <= 5; j++) begin
            cyc(1'b0, 4'd0, 64'h0, 1'b1, 5'd16, 1'b0, 64'h0, 1'b0);
            check_state($sformatf("drain%0d", j), 128 - 16*j, 16, 64'(16*j), j == 5, 1'b0);
        end

        // Walk the write pointer to 124 at constant occupancy, then fill across the wrap
        for (int j = 1; j <= 15; j++) begin
            fill_seq(4'd8, 1'b1, 5'd8);
            check_state($sformatf("walk%0d", j), 48, 16, 64'(80 + 8*j), 1'b1, 1'b0);
        end
        fill_seq(4'd4, 1'b0, 5'd0);
        check_state("pre_wrap", 52, 16, 64'd200, 1'b1, 1'b0);
        cyc(1'b1, 4'd8, 64'hA7A6A5A4A3A2A1A0, 1'b0, 5'd0, 1'b0, 64'h0, 1'b0);
        check_state("wrap_fill", 60, 16, 64'd200, 1'b1, 1'b0);
        for (int j = 1; j <= 3; j++) begin
            cyc(1'b0, 4'd0, 64'h0, 1'b1, 5'd16, 1'b0, 64'h0, 1'b0);
            check_state($sformatf("wrap_take%0d", j), 60 - 16*j, (j == 3) ? 12 : 16,
                        64'(200 + 16*j), 1'b1, 1'b0);
        end
        chk("wrap.byte4_A0", 64'(win_data[39:32]), 64'hA0);
        chk("wrap.byte11_A7", 64'(win_data[95:88]), 64'hA7);

        // Reset mid-stream overrides a concurrent fill and an over-long take
        cyc(1'b1, 4'd8, seq_beat(), 1'b1, 5'd20, 1'b0, 64'h0, 1'b1);
        check_state("midrst", 0, 0, 64'h0, 1'b1, 1'b0);
        cyc(1'b0, 4'd0, 64'h0, 1'b0, 5'd0, 1'b0, 64'h0, 1'b0);
        check_state("midrst_idle", 0, 0, 64'h0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
